bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Parametrised arbiter for one shared BRAM port; replaces the static two-way CPU/MemAccess address mux.
- Up to NUM_MASTERS requesters (CPU fetch, CPU load/store, UART MemAccess, future DMA) compete per cycle.
- Grant is round-robin or fixed priority, with optional per-master lock and out-of-range address checking.
- Tagged read-return pipeline matches BRAM read latency, so each master gets its own rvalid.

Parameters:
- NUM_MASTERS, 3, number of requesters (2..8).
- ADDR_W, 16, byte address width per master.
- ROW_BITS, 13, BRAM word-row address width; valid bytes = 4*2^ROW_BITS.
- DATA_W, 32, data width; must be a multiple of 8.
- READ_LATENCY, 1, BRAM clocks from address to dout (1..3).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (master 0 highest).

Ports:
- clk  in  1  system clock (clk_out1 domain).
- rst  in  1  asynchronous, active-high reset.
- m_req  in  NUM_MASTERS  per-master access request.
- m_lock  in  NUM_MASTERS  hold grant on this master while asserted.
- m_we  in  NUM_MASTERS*DATA_W/8  per-master byte write enables; all zero = read.
- m_addr  in  NUM_MASTERS*ADDR_W  per-master byte address.
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data.
- m_gnt  out  NUM_MASTERS  one-hot accept, combinational, same cycle as accept.
- m_rvalid  out  NUM_MASTERS  one-hot read-data valid.
- m_rdata  out  DATA_W  read data, shared by all masters; qualified by m_rvalid.
- m_err  out  NUM_MASTERS  1-cycle pulse on an out-of-range access.
- mem_we  out  DATA_W/8  to BRAM port.
- mem_addr  out  ROW_BITS  word row, taken from addr[ROW_BITS+1:2].
- mem_din  out  DATA_W  to BRAM port.
- mem_dout  in  DATA_W  from BRAM port.

Behaviour:
Reset (async assert, sync release):
- Pointer ptr = 0, lock owner = none.
- Read-tag pipeline cleared.
- m_rvalid, m_err = 0.
- Pending reads are dropped; none is ever returned after reset.

Grant (combinational):
- At most one m_gnt bit per cycle; m_gnt[i] implies m_req[i].
- No request: m_gnt = 0, mem_we = 0, mem_addr/mem_din hold the last-granted values (registered mux select).
- Round-robin: first requesting master at or after ptr, searching circularly.
- Fixed priority: lowest requesting index wins.
- Lock: if master L was granted with m_lock[L] = 1 and still has m_req[L] = 1, L wins unconditionally. The lock is released when m_lock[L] or m_req[L] drops.

Pointer update (registered, on grant to g):
- Round-robin: ptr <= (g+1) mod NUM_MASTERS; wraps from NUM_MASTERS-1 to 0.
- Lock held: ptr frozen.

Port drive:
- mem_we = m_we[g] when in range, else 0.
- mem_addr = row bits of m_addr[g]; mem_din = m_wdata[g].
- Byte offset addr[1:0] is ignored; word aligned.

Range check:
- Out of range: any of m_addr[g][ADDR_W-1:ROW_BITS+2] set, evaluated only when ADDR_W > ROW_BITS+2.
- Effect: write suppressed, and m_err[g] pulses the cycle after grant.
- A read still returns, with m_rdata forced to 0.

Read return:
- Every granted read (m_we[g] == 0) pushes tag {valid, g, err} into a READ_LATENCY-deep shift register.
- At the output: m_rvalid[tag.g] = 1 and m_rdata = mem_dout (0 if tag.err).
- Writes push an invalid tag.
- Back-to-back reads from different masters return in issue order, one per cycle, at full throughput.

Simultaneous events:
- A write and a read to the same row in consecutive grants return per BRAM write-first mode; the arbiter does not add forwarding.
- The request/grant handshake holds: a master keeps m_req, m_addr, m_we and m_wdata stable until m_gnt is seen.

Test Plan:
- NUM_MASTERS=3, ARB_MODE=0, all req held high for 6 cycles -> gnt sequence 0,1,2,0,1,2; ptr wraps 2 -> 0.
- ARB_MODE=1, req=3'b110 then 3'b111 -> gnt = 1 then gnt = 0; master 2 starves while req[0] is held.
- Master 1 with m_lock=1 and req=1 for 4 cycles, others requesting -> gnt[1] for all 4. Drop lock -> next grant goes to master 2 (ptr = 2).
- READ_LATENCY=2: master 0 writes 0xDEADBEEF to addr 0x0010 with we=4'hF, then master 2 reads 0x0012 -> m_rvalid[2] exactly 2 cycles after grant, m_rdata = 0xDEADBEEF, mem_addr = 4.
- Write to addr 0x8000 (ROW_BITS=13) -> mem_we = 0, m_err pulses for that master, BRAM unchanged. A read of the same address -> rvalid with rdata = 0.
- Assert rst while two reads are in flight -> m_rvalid stays 0 through the following READ_LATENCY cycles; after release, first grant goes to master 0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - Shared BRAM port arbiter with tagged read return
// Round-robin or fixed-priority grant, optional lock, range check and per-master rvalid.
module bram_port_arbiter #(
  parameter int NUM_MASTERS  = 3,
  parameter int ADDR_W       = 16,
  parameter int ROW_BITS     = 13,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS-1:0]          m_lock,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]          m_gnt,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic [DATA_W/8-1:0]             mem_we,
  output logic [ROW_BITS-1:0]             mem_addr,
  output logic [DATA_W-1:0]               mem_din,
  input  logic [DATA_W-1:0]               mem_dout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] sel;
  logic             lock_v_q;
  logic             lock_active;
  logic             gnt_any;
  logic             oor;
  logic             is_read;
  logic [BE_W-1:0]  we_sel;

  logic [READ_LATENCY-1:0]            tag_v_q;
  logic [READ_LATENCY-1:0]            tag_e_q;
  logic [READ_LATENCY-1:0][IDX_W-1:0] tag_g_q;

  always_comb begin : arb
    logic [IDX_W-1:0] cand;
    cand        = '0;
    gnt_any     = 1'b0;
    gnt_idx     = '0;
    lock_active = lock_v_q && m_req[lock_idx_q] && m_lock[lock_idx_q];
    if (lock_active) begin
      gnt_any = 1'b1;
      gnt_idx = lock_idx_q;
    end else if (ARB_MODE != 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (m_req[i]) begin
          gnt_any = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end else begin
      // Walk backwards so the requester closest to ptr is the last to overwrite.
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(ptr_q) + k) % NUM_MASTERS);
        if (m_req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // The port mux keeps pointing at the last granted master while idle.
  assign sel = gnt_any ? gnt_idx : sel_q;

  generate
    if (ADDR_W > ROW_BITS + 2) begin : g_range
      assign oor = |m_addr[int'(sel)*ADDR_W + ROW_BITS + 2 +: ADDR_W - ROW_BITS - 2];
    end else begin : g_norange
      assign oor = 1'b0;
    end
  endgenerate

  always_comb begin
    we_sel   = m_we[int'(sel)*BE_W +: BE_W];
    mem_addr = m_addr[int'(sel)*ADDR_W + 2 +: ROW_BITS];
    mem_din  = m_wdata[int'(sel)*DATA_W +: DATA_W];
    is_read  = ~|we_sel;
    mem_we   = (gnt_any && !oor) ? we_sel : '0;
    m_gnt    = '0;
    if (gnt_any) m_gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_v_q   <= 1'b0;
      lock_idx_q <= '0;
      sel_q      <= '0;
      m_err      <= '0;
      tag_v_q    <= '0;
      tag_e_q    <= '0;
      tag_g_q    <= '0;
    end else begin
      m_err <= '0;
      if (gnt_any) begin
        sel_q      <= gnt_idx;
        lock_v_q   <= m_lock[gnt_idx];
        lock_idx_q <= gnt_idx;
        if (oor) m_err[gnt_idx] <= 1'b1;
        if (ARB_MODE == 0 && !lock_active)
          ptr_q <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
      end else begin
        lock_v_q <= 1'b0;
      end
      tag_v_q[0] <= gnt_any && is_read;
      tag_e_q[0] <= oor;
      tag_g_q[0] <= gnt_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_e_q[i] <= tag_e_q[i-1];
        tag_g_q[i] <= tag_g_q[i-1];
      end
    end
  end

  always_comb begin
    m_rvalid = '0;
    if (tag_v_q[READ_LATENCY-1]) m_rvalid[tag_g_q[READ_LATENCY-1]] = 1'b1;
    m_rdata = tag_e_q[READ_LATENCY-1] ? '0 : mem_dout;
  end

endmodule
